// File: rtl/instr_bus_decoder_pkg.sv
// Shared instruction-side address map and fetch target identifiers.
package microsoc_pkg;

   typedef enum logic [1:0] {
      TGT_ROM = 2'd0,
      TGT_RAM = 2'd1,
      TGT_ERR = 2'd2
   } instr_tgt_e;

   // Boot ROM occupies the lowest 256 bytes
   localparam logic [31:0] ROM_BASE     = 32'h0000_0000;
   localparam logic [31:0] ROM_MASK     = 32'hFFFF_FF00;
   localparam logic [31:0] RAM_BASE_DEF = 32'h0001_0000;
   localparam logic [31:0] RAM_MASK_DEF = 32'hFFFF_0000;

   // ROM is checked first so it wins if the RAM window overlaps it
   function automatic instr_tgt_e decode_tgt(input logic [31:0] addr,
                                             input logic [31:0] ram_base,
                                             input logic [31:0] ram_mask);
      if ((addr & ROM_MASK) == ROM_BASE)
         return TGT_ROM;
      else if ((addr & ram_mask) == ram_base)
         return TGT_RAM;
      else
         return TGT_ERR;
   endfunction

endpackage

// File: rtl/instr_bus_decoder_tag_fifo.sv
// In-order FIFO of fetch target IDs for granted, not yet answered fetches.
module instr_tag_fifo
   import microsoc_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  instr_tgt_e push_tgt,
   input  logic       pop,
   output instr_tgt_e head_tgt,
   output logic       full,
   output logic       empty
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

   instr_tgt_e    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   // Pointers wrap at DEPTH-1 so non-power-of-two depths work
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= TGT_ERR;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_tgt;
            wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Status flags and head entry
   always_comb begin
      full     = (count == DEPTH_C);
      empty    = (count == '0);
      head_tgt = mem[rd_ptr];
   end

endmodule

// File: rtl/instr_bus_decoder.sv
// Routes core instruction fetches to boot ROM, instruction RAM or an
// internal error responder, returning responses strictly in grant order.
module instr_bus_decoder
   import microsoc_pkg::*;
#(
   parameter int unsigned  DEPTH    = 2,
   parameter logic [31:0]  RAM_BASE = RAM_BASE_DEF,
   parameter logic [31:0]  RAM_MASK = RAM_MASK_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   input  logic [31:0] instr_addr_i,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic [6:0]  instr_rdata_intg_o,
   output logic        instr_err_o,
   output logic        rom_req_o,
   output logic [31:0] rom_addr_o,
   input  logic        rom_gnt_i,
   input  logic        rom_rvalid_i,
   input  logic [31:0] rom_rdata_i,
   input  logic [6:0]  rom_rdata_intg_i,
   input  logic        rom_err_i,
   output logic        ram_req_o,
   output logic [31:0] ram_addr_o,
   input  logic        ram_gnt_i,
   input  logic        ram_rvalid_i,
   input  logic [31:0] ram_rdata_i,
   input  logic [6:0]  ram_rdata_intg_i,
   input  logic        ram_err_i,
   output logic        protocol_err_o
);

   instr_tgt_e req_tgt;
   instr_tgt_e head_tgt;
   logic       full;
   logic       empty;
   logic       slave_gnt;
   logic       can_issue;

   instr_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (instr_gnt_o),
      .push_tgt (req_tgt),
      .pop      (instr_rvalid_o),
      .head_tgt (head_tgt),
      .full     (full),
      .empty    (empty)
   );

   // Request decode and grant; rst gating keeps the core side quiet in reset
   always_comb begin
      req_tgt = decode_tgt(instr_addr_i, RAM_BASE, RAM_MASK);
      case (req_tgt)
         TGT_ROM: slave_gnt = rom_gnt_i;
         TGT_RAM: slave_gnt = ram_gnt_i;
         default: slave_gnt = 1'b1;
      endcase
      can_issue   = rst & instr_req_i & ~full;
      rom_req_o   = can_issue & (req_tgt == TGT_ROM);
      ram_req_o   = can_issue & (req_tgt == TGT_RAM);
      instr_gnt_o = can_issue & slave_gnt;
      rom_addr_o  = instr_addr_i;
      ram_addr_o  = instr_addr_i;
   end

   // Response mux selected by the oldest outstanding tag
   always_comb begin
      instr_rvalid_o     = 1'b0;
      instr_rdata_o      = '0;
      instr_rdata_intg_o = '0;
      instr_err_o        = 1'b0;
      if (!empty) begin
         case (head_tgt)
            TGT_ROM: begin
               instr_rvalid_o     = rom_rvalid_i;
               instr_rdata_o      = rom_rdata_i;
               instr_rdata_intg_o = rom_rdata_intg_i;
               instr_err_o        = rom_err_i;
            end
            TGT_RAM: begin
               instr_rvalid_o     = ram_rvalid_i;
               instr_rdata_o      = ram_rdata_i;
               instr_rdata_intg_o = ram_rdata_intg_i;
               instr_err_o        = ram_err_i;
            end
            default: begin
               instr_rvalid_o = 1'b1;
               instr_err_o    = 1'b1;
            end
         endcase
      end
   end

   // Sticky flag for slave responses that do not match the head tag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         protocol_err_o <= 1'b0;
      else if ((rom_rvalid_i && (empty || head_tgt != TGT_ROM)) ||
               (ram_rvalid_i && (empty || head_tgt != TGT_RAM)))
         protocol_err_o <= 1'b1;
   end

endmodule

// File: doc/instr_bus_decoder.md
INSTR_BUS_DECODER -- requirements
Module: instr_bus_decoder

Interface
REQ-001 Parameter DEPTH, default 2, maximum outstanding granted fetches; legal values 1..4.
REQ-002 Parameter RAM_BASE, default 32'h0001_0000, RAM window base.
REQ-003 Parameter RAM_MASK, default 32'hFFFF_0000, RAM window compare mask.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 instr_req_i / instr_gnt_o / instr_addr_i[31:0]  core side  request, grant and word address.
REQ-007 instr_rvalid_o / instr_rdata_o[31:0] / instr_rdata_intg_o[6:0] / instr_err_o  output  core-side response.
REQ-008 rom_req_o / rom_addr_o[31:0] out, rom_gnt_i / rom_rvalid_i / rom_rdata_i[31:0] / rom_rdata_intg_i[6:0] / rom_err_i in  boot ROM port.
REQ-009 ram_* signals, same set and directions as rom_*  instruction RAM port.
REQ-010 protocol_err_o  output  1  sticky flag for an unexpected slave response.

Function
REQ-011 Decode: ROM when addr[31:8]==0; RAM when (addr & RAM_MASK)==RAM_BASE; otherwise ERR; ROM wins on overlap.
REQ-012 rom_req_o = instr_req_i & target ROM & ~full; ram_req_o likewise; unselected slave req held 0.
REQ-013 *_addr_o driven with instr_addr_i unchanged to both slaves.
REQ-014 instr_gnt_o = instr_req_i & ~full & (ROM: rom_gnt_i | RAM: ram_gnt_i | ERR: 1).
REQ-015 full = (count == DEPTH); no grant while full, even if a pop occurs the same cycle.
REQ-016 Each grant pushes the target ID into an in-order tag FIFO of DEPTH entries.
REQ-017 Head ROM: core response fields = rom_* response inputs; instr_rvalid_o = rom_rvalid_i.
REQ-018 Head RAM: same rule using ram_* inputs.
REQ-019 Head ERR: instr_rvalid_o=1, instr_err_o=1, instr_rdata_o=0, intg=0; earliest cycle is the one after its grant.
REQ-020 FIFO empty: instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, intg=0.
REQ-021 Pop the head whenever instr_rvalid_o=1; push and pop in the same cycle leave count unchanged.
REQ-022 Responses are returned strictly in grant order; no reordering.
REQ-023 Slave rvalid while its ID is not at the FIFO head (including FIFO empty): response dropped, no pop, protocol_err_o set.
REQ-024 protocol_err_o, once set, is cleared only by reset.
REQ-025 Pointers wrap modulo DEPTH; count is range 0..DEPTH.

Reset
REQ-026 While rst=0: FIFO empty, count=0, pointers=0, protocol_err_o=0.
REQ-027 While rst=0: instr_gnt_o=0, rom_req_o=0, ram_req_o=0, instr_rvalid_o=0.
REQ-028 Reset mid-operation discards all outstanding tags; late slave responses after release set protocol_err_o.

Structure
REQ-029 Shared package microsoc_pkg holds the instr_tgt_e enum (TGT_ROM, TGT_RAM, TGT_ERR) and the ROM/RAM address-map constants.
REQ-030 Tag FIFO is a separate sub-module, instr_tag_fifo (parameter DEPTH, element instr_tgt_e, flags full/empty).

Verification
REQ-031 ROM fetch: req at 0x80 with rom_gnt=1 -> gnt same cycle; rvalid next cycle with rdata=0x00000513, err=0.
REQ-032 Unmapped fetch: req at 0x4000_0000 -> gnt same cycle, no slave req; next cycle rvalid=1, err=1, rdata=0.
REQ-033 Ordering: ROM grant, then RAM grant; RAM rvalid arrives first -> dropped, protocol_err_o=1; the ROM response is still delivered first.
REQ-034 Back-pressure (DEPTH=2): two grants with no response -> third req sees gnt=0 and rom_req_o=0 until one response pops.
REQ-035 Reset with 2 outstanding: assert rst=0 -> count=0, gnt=0; after release, a fresh ROM fetch at 0x84 returns 0x000015b7.
REQ-036 Mixed stream: ROM, ERR, RAM back to back -> three responses in order with err flags 0, 1, 0.
